// File: rtl/fechadura_sequencial_param.sv
// ---------------------------------------------------------------------------
// fechadura_sequencial_param
// Parametrised sequential code lock. The user enters N_DIGITS digits on a
// keypad. Each digit is compared with the matching digit of 'code'. The
// verdict is given only after the last digit, so a probe cannot tell which
// digit was wrong. MAX_TRIES failed entries in a row start a timed lockout.
//
// Ports:
//   clk        : rising-edge clock
//   reset_n    : asynchronous, active-low reset
//   l          : synchronous clear / relock request
//   p          : key-pressed level from the debouncer
//   digit      : digit value, valid while p=1
//   code       : expected code, digit k at [k*DIGIT_W +: DIGIT_W], digit 0 first
//   u          : unlocked
//   err        : last entry failed
//   locked_out : lockout active
//   s          : digits accepted in the current entry
//   tries_left : remaining attempts before lockout
//
// Optional feature, macro AUTO_RELOCK_EN: when defined, UNLOCK relocks by
// itself after RELOCK_CYCLES cycles unless l ends it earlier.
// ---------------------------------------------------------------------------
module fechadura_sequencial_param #(
  parameter int N_DIGITS       = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 100,
  parameter int RELOCK_CYCLES  = 200
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                l,
  input  logic                                p,
  input  logic [DIGIT_W-1:0]                  digit,
  input  logic [N_DIGITS*DIGIT_W-1:0]         code,
  output logic                                u,
  output logic                                err,
  output logic                                locked_out,
  output logic [$clog2(N_DIGITS+1)-1:0]       s,
  output logic [$clog2(MAX_TRIES+1)-1:0]      tries_left
);

  localparam int S_W  = $clog2(N_DIGITS+1);
  localparam int T_W  = $clog2(MAX_TRIES+1);
  localparam int LK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [S_W-1:0]  IDX_FULL  = S_W'(N_DIGITS);
  localparam logic [T_W-1:0]  TRIES_MAX = T_W'(MAX_TRIES);
  localparam logic [LK_W-1:0] LOCK_LOAD = LK_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ENTRY    = 3'd0,
    WAIT_REL = 3'd1,
    ERROR    = 3'd2,
    UNLOCK   = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  state_t           r_state, w_nextState;
  logic [S_W-1:0]   r_idx, w_nextIdx;
  logic             r_mism, w_nextMism;
  logic [T_W-1:0]   r_tries, w_nextTries;
  logic [LK_W-1:0]  r_lockTimer, w_nextLockTimer;
  logic             r_u, r_err, r_lockedOut;
  logic             w_nextU, w_nextErr, w_nextLockedOut;
  logic [DIGIT_W-1:0] w_codeDigit;

`ifdef AUTO_RELOCK_EN
  localparam int RL_W = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
  localparam logic [RL_W-1:0] RELOCK_LOAD = RL_W'(RELOCK_CYCLES - 1);
  logic [RL_W-1:0]  r_relockTimer, w_nextRelockTimer;
`else
  logic [31:0] w_unusedRelock;
  assign w_unusedRelock = 32'(RELOCK_CYCLES);
`endif

  // Select the code digit for the current position with an explicit mux so
  // an out-of-range index simply yields zero.
  always_comb begin
    w_codeDigit = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == S_W'(k)) w_codeDigit = code[k*DIGIT_W +: DIGIT_W];
    end
  end

  // State register plus datapath registers and the registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ENTRY;
      r_idx       <= '0;
      r_mism      <= 1'b0;
      r_tries     <= TRIES_MAX;
      r_lockTimer <= '0;
      r_u         <= 1'b0;
      r_err       <= 1'b0;
      r_lockedOut <= 1'b0;
`ifdef AUTO_RELOCK_EN
      r_relockTimer <= '0;
`endif
    end else begin
      r_state     <= w_nextState;
      r_idx       <= w_nextIdx;
      r_mism      <= w_nextMism;
      r_tries     <= w_nextTries;
      r_lockTimer <= w_nextLockTimer;
      r_u         <= w_nextU;
      r_err       <= w_nextErr;
      r_lockedOut <= w_nextLockedOut;
`ifdef AUTO_RELOCK_EN
      r_relockTimer <= w_nextRelockTimer;
`endif
    end
  end

  // Next-state logic. The mismatch flag is accumulated silently and only
  // consulted once the final key is released.
  always_comb begin
    w_nextState     = r_state;
    w_nextIdx       = r_idx;
    w_nextMism      = r_mism;
    w_nextTries     = r_tries;
    w_nextLockTimer = r_lockTimer;
`ifdef AUTO_RELOCK_EN
    w_nextRelockTimer = r_relockTimer;
`endif
    case (r_state)
      ENTRY: begin
        if (l) begin
          w_nextIdx  = '0;
          w_nextMism = 1'b0;
        end else if (p) begin
          w_nextMism  = r_mism | (digit != w_codeDigit);
          w_nextIdx   = r_idx + S_W'(1);
          w_nextState = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (l) begin
          w_nextState = ENTRY;
          w_nextIdx   = '0;
          w_nextMism  = 1'b0;
        end else if (!p) begin
          if (r_idx == IDX_FULL) begin
            w_nextIdx  = '0;
            w_nextMism = 1'b0;
            if (!r_mism) begin
              w_nextState = UNLOCK;
              w_nextTries = TRIES_MAX;
`ifdef AUTO_RELOCK_EN
              w_nextRelockTimer = RELOCK_LOAD;
`endif
            end else if (r_tries > T_W'(1)) begin
              w_nextState = ERROR;
              w_nextTries = r_tries - T_W'(1);
            end else begin
              w_nextState     = LOCKOUT;
              w_nextTries     = '0;
              w_nextLockTimer = LOCK_LOAD;
            end
          end else begin
            w_nextState = ENTRY;
          end
        end
      end
      ERROR: begin
        if (l) w_nextState = ENTRY;
      end
      UNLOCK: begin
        if (l) begin
          w_nextState = ENTRY;
        end
`ifdef AUTO_RELOCK_EN
        else if (r_relockTimer == '0) begin
          w_nextState = ENTRY;
        end else begin
          w_nextRelockTimer = r_relockTimer - RL_W'(1);
        end
`endif
      end
      LOCKOUT: begin
        // The timer is loaded with LOCKOUT_CYCLES-1 on entry, so leaving at
        // zero gives exactly LOCKOUT_CYCLES cycles in this state.
        if (r_lockTimer == '0) begin
          w_nextState = ENTRY;
          w_nextTries = TRIES_MAX;
        end else begin
          w_nextLockTimer = r_lockTimer - LK_W'(1);
        end
      end
      default: begin
        w_nextState = ENTRY;
        w_nextIdx   = '0;
        w_nextMism  = 1'b0;
      end
    endcase
  end

  // Output decode from the next state, so the flags register on the same
  // edge as the state itself.
  always_comb begin
    w_nextU         = (w_nextState == UNLOCK);
    w_nextErr       = (w_nextState == ERROR);
    w_nextLockedOut = (w_nextState == LOCKOUT);
  end

  assign u          = r_u;
  assign err        = r_err;
  assign locked_out = r_lockedOut;
  assign s          = r_idx;
  assign tries_left = r_tries;

endmodule

// File: tb/tb_fechadura_sequencial_param.sv
module tb_fechadura_sequencial_param;

  localparam int LOCK_A   = 100;
  localparam int LOCK_B   = 7;
  localparam int RELOCK_B = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        lA, pA, uA, errA, loA;
  logic [3:0]  digitA;
  logic [15:0] codeA;
  logic [2:0]  sA;
  logic [1:0]  triesA;

  logic        lB, pB, uB, errB, loB;
  logic [7:0]  digitB;
  logic [47:0] codeB;
  logic [2:0]  sB;
  logic [0:0]  triesB;

  int checks = 0;
  int errors = 0;

  // Reference model: digits typed so far, remaining tries, and what the lock
  // is showing (0 entry, 1 unlocked, 2 error, 3 lockout).
  logic [3:0] mQ[$];
  int mTries;
  int mode;

  fechadura_sequencial_param dutA (
    .clk(clk), .reset_n(reset_n), .l(lA), .p(pA), .digit(digitA), .code(codeA),
    .u(uA), .err(errA), .locked_out(loA), .s(sA), .tries_left(triesA)
  );

  fechadura_sequencial_param #(
    .N_DIGITS(6), .DIGIT_W(8), .MAX_TRIES(1),
    .LOCKOUT_CYCLES(LOCK_B), .RELOCK_CYCLES(RELOCK_B)
  ) dutB (
    .clk(clk), .reset_n(reset_n), .l(lB), .p(pB), .digit(digitB), .code(codeB),
    .u(uB), .err(errB), .locked_out(loB), .s(sB), .tries_left(triesB)
  );

  // Watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic evaluateA();
    bit match;
    match = 1'b1;
    for (int k = 0; k < 4; k++) if (mQ[k] != codeA[k*4 +: 4]) match = 1'b0;
    mQ.delete();
    if (match) begin
      mTries = 3; mode = 1;
    end else if (mTries > 1) begin
      mTries--; mode = 2;
    end else begin
      mTries = 0; mode = 3;
    end
    checkOutput("verdict_u", uA, mode == 1);
    checkOutput("verdict_err", errA, mode == 2);
    checkOutput("verdict_lockout", loA, mode == 3);
    checkOutput("verdict_tries", triesA, mTries);
    checkOutput("verdict_s", sA, 0);
  endtask

  // One key press on lock A: p high for 'hold' cycles, then one cycle low.
  task automatic applyStimulus(input logic [3:0] d, input int hold);
    pA = 1'b1;
    digitA = d;
    for (int c = 0; c < hold; c++) begin
      tick();
      checkOutput("s_during_press", sA, mQ.size() + 1);
    end
    mQ.push_back(d);
    pA = 1'b0;
    tick();
    if (mQ.size() < 4) begin
      checkOutput("s_after_release", sA, mQ.size());
      checkOutput("u_mid_entry", uA, 0);
      checkOutput("err_mid_entry", errA, 0);
    end else begin
      evaluateA();
    end
  endtask

  task automatic entryA(input logic [15:0] digits);
    for (int k = 0; k < 4; k++) applyStimulus(digits[k*4 +: 4], 1);
  endtask

  task automatic clearA(input string tag);
    pA = 1'b0;
    lA = 1'b1;
    tick();
    lA = 1'b0;
    mode = 0;
    mQ.delete();
    checkOutput({tag, "_u"}, uA, 0);
    checkOutput({tag, "_err"}, errA, 0);
    checkOutput({tag, "_s"}, sA, 0);
    checkOutput({tag, "_tries"}, triesA, mTries);
  endtask

  // Called right after the verdict that entered lockout; counts the cycles
  // locked_out stays high while throwing ignored keys and clears at it.
  task automatic waitLockoutA(input bit noise);
    int cnt;
    cnt = 1;
    while (cnt <= LOCK_A + 5) begin
      if (noise && cnt < LOCK_A - 2) begin
        pA = 1'($urandom_range(0, 1));
        lA = 1'($urandom_range(0, 1));
        digitA = 4'($urandom);
      end else begin
        pA = 1'b0;
        lA = 1'b0;
      end
      tick();
      if (!loA) break;
      cnt++;
    end
    pA = 1'b0;
    lA = 1'b0;
    checkOutput("lockout_len", cnt, LOCK_A);
    mode = 0;
    mTries = 3;
    checkOutput("after_lockout_tries", triesA, 3);
    checkOutput("after_lockout_s", sA, 0);
    checkOutput("after_lockout_u", uA, 0);
  endtask

  task automatic asyncReset(input string tag);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput({tag, "_u"}, uA, 0);
    checkOutput({tag, "_err"}, errA, 0);
    checkOutput({tag, "_lockout"}, loA, 0);
    checkOutput({tag, "_s"}, sA, 0);
    checkOutput({tag, "_tries"}, triesA, 3);
    pA = 1'b0;
    lA = 1'b0;
    #1;
    reset_n = 1'b1;
    mTries = 3;
    mode = 0;
    mQ.delete();
  endtask

  task automatic pressB(input logic [7:0] d, input int expS);
    pB = 1'b1;
    digitB = d;
    tick();
    checkOutput("b_s_press", sB, expS);
    pB = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int cnt;
    bit wrong;
    logic [3:0] d4;
    logic [7:0] d8;

    reset_n = 1'b0;
    lA = 0; pA = 0; digitA = '0; codeA = 16'h2594;
    lB = 0; pB = 0; digitB = '0; codeB = {16'($urandom), 32'($urandom)};
    mTries = 3; mode = 0;
    #17;
    checkOutput("reset_u", uA, 0);
    checkOutput("reset_err", errA, 0);
    checkOutput("reset_lockout", loA, 0);
    checkOutput("reset_s", sA, 0);
    checkOutput("reset_tries", triesA, 3);
    checkOutput("reset_b_tries", triesB, 1);
    reset_n = 1'b1;
    tick();

    $display("[TB] correct entry");
    entryA(16'h2594);
    pA = 1'b1; digitA = 4'h4;
    tick();
    checkOutput("unlock_ignores_p_s", sA, 0);
    checkOutput("unlock_ignores_p_u", uA, 1);
    pA = 1'b0;
    tick();
    clearA("clear_unlock");

    $display("[TB] l beats p");
    pA = 1'b1; lA = 1'b1; digitA = 4'h4;
    tick();
    checkOutput("l_priority_s", sA, 0);
    pA = 1'b0; lA = 1'b0;
    tick();

    $display("[TB] wrong entry");
    entryA(16'h1594);
    clearA("clear_error");
    entryA(16'h2594);
    clearA("clear_unlock2");

    $display("[TB] lockout");
    entryA(16'h1594); clearA("w1");
    entryA(16'h1594); clearA("w2");
    entryA(16'h1594);
    waitLockoutA(1'b1);

    $display("[TB] held key and abort");
    applyStimulus(4'h4, 10);
    applyStimulus(4'h9, 1);
    clearA("abort");
    entryA(16'h2594);
    clearA("clear_unlock3");

    $display("[TB] async reset");
    entryA(16'h1594); clearA("pre_reset");
    applyStimulus(4'h4, 1);
    pA = 1'b1; digitA = 4'h9;
    tick();
    checkOutput("wait_rel_s", sA, 2);
    asyncReset("reset_wait_rel");
    tick();
    entryA(16'h1594); clearA("l1");
    entryA(16'h1594); clearA("l2");
    entryA(16'h1594);
    repeat (20) tick();
    checkOutput("mid_lockout", loA, 1);
    asyncReset("reset_lockout");
    tick();

    $display("[TB] six-digit lock");
    for (int k = 0; k < 6; k++) begin
      d8 = codeB[k*8 +: 8];
      if (k == 3) d8 = d8 ^ 8'h5A;
      pressB(d8, k + 1);
      if (k < 5) checkOutput("b_s_release", sB, k + 1);
    end
    checkOutput("b_lockout", loB, 1);
    checkOutput("b_err", errB, 0);
    checkOutput("b_tries0", triesB, 0);
    cnt = 1;
    while (cnt <= LOCK_B + 5) begin
      tick();
      if (!loB) break;
      cnt++;
    end
    checkOutput("b_lockout_len", cnt, LOCK_B);
    checkOutput("b_tries_restored", triesB, 1);
    for (int k = 0; k < 6; k++) pressB(codeB[k*8 +: 8], k + 1);
    checkOutput("b_unlock", uB, 1);
    cnt = 1;
    while (cnt <= 20) begin
      tick();
      if (!uB) break;
      cnt++;
    end
`ifdef AUTO_RELOCK_EN
    checkOutput("b_relock_len", cnt, RELOCK_B);
`else
    checkOutput("b_unlock_holds", cnt, 21);
    lB = 1'b1;
    tick();
    lB = 1'b0;
    checkOutput("b_clear_u", uB, 0);
`endif
    checkOutput("b_after_s", sB, 0);

    $display("[TB] random entries");
    for (int r = 0; r < 30; r++) begin
      codeA = 16'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) applyStimulus(4'($urandom), $urandom_range(1, 3));
        clearA("rand_abort");
      end else begin
        wrong = 1'($urandom_range(0, 1));
        for (int k = 0; k < 4; k++) begin
          d4 = wrong ? 4'($urandom) : codeA[k*4 +: 4];
          applyStimulus(d4, $urandom_range(1, 4));
          if (k < 3) begin
            repeat ($urandom_range(0, 2)) begin
              tick();
              checkOutput("rand_idle_s", sA, mQ.size());
            end
          end
        end
        if (mode == 3) waitLockoutA(1'b1);
        else clearA("rand_clear");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
